// File: rtl/chan_mm_bridge_pkg.sv
// Shared link-engine definitions for the channel register bridge:
// FSM state encoding, timeout error word and sticky-error bit positions.
package chan_mm_bridge_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StWr      = 3'd1;
  localparam state_t StRdIssue = 3'd2;
  localparam state_t StRdWait  = 3'd3;
  localparam state_t StRdResp  = 3'd4;

  // Upper 32 bits of the word returned to the host when a read times out.
  localparam logic [31:0] ErrWord = 32'hDEAD_BEEF;

  // Positions within oERR_STICKY.
  localparam int unsigned ErrBitTo = 0;
  localparam int unsigned ErrBitRw = 1;

  // Width of the read wait counter; covers the full legal TIMEOUT range.
  localparam int unsigned TimerW = 16;

endpackage

// File: rtl/chan_mm_bridge_mm_rd_timer.sv
// Read wait counter: cleared when a read is accepted, counts while the
// bridge waits for the decoder, and flags the last allowed wait cycle.
module mm_rd_timer
  import chan_mm_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TimerW-1:0] LastCnt = TimerW'(TIMEOUT - 1);

  logic [TimerW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TimerW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LastCnt);

endmodule

// File: rtl/chan_mm_bridge.sv
// Host-side front end for one channel's register space. Converts single-beat
// host reads/writes (waitrequest handshake) into one-cycle decoder strobes and
// bounds every read with a timeout that returns a fixed error word.
module chan_mm_bridge
  import chan_mm_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] iAV_ADDR,
  input  logic              iAV_WRITE,
  input  logic              iAV_READ,
  input  logic [DATA_W-1:0] iAV_WRDATA,
  output logic              oAV_WAITREQ,
  output logic [DATA_W-1:0] oAV_RDDATA,
  output logic              oAV_RDDATA_V,
  output logic [ADDR_W-1:0] oMM_ADDR,
  output logic              oMM_WR_EN,
  output logic              oMM_RD_EN,
  output logic [DATA_W-1:0] oMM_WR_DATA,
  input  logic [DATA_W-1:0] iMM_RD_DATA,
  input  logic              iMM_RD_DATA_V,
  input  logic              iCLR_ERR,
  output logic [15:0]       oTO_CNT,
  output logic [1:0]        oERR_STICKY
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              rd_v_q, rd_v_d;
  logic [15:0]       to_cnt_q, to_cnt_d;
  logic [1:0]        sticky_q, sticky_d;

  logic              tmr_clr, tmr_en, tmr_expired;
  logic              err_to, err_rw;
  logic [DATA_W-1:0] err_data;

  mm_rd_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_rd_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Timeout response: error tag on top, captured address at the bottom.
  always_comb begin
    err_data = '0;
    err_data[ADDR_W-1:0] = addr_q;
    err_data[DATA_W-1 -: 32] = ErrWord;
  end

  // Transaction FSM, capture registers and strobe generation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    err_to  = 1'b0;
    err_rw  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Write wins over a simultaneous read; the read is dropped.
        if (iAV_WRITE) begin
          addr_d  = iAV_ADDR;
          wdata_d = iAV_WRDATA;
          err_rw  = iAV_READ;
          state_d = StWr;
        end else if (iAV_READ) begin
          addr_d  = iAV_ADDR;
          tmr_clr = 1'b1;
          state_d = StRdIssue;
        end
      end
      StWr: begin
        state_d = StIdle;
      end
      StRdIssue: begin
        if (iMM_RD_DATA_V) begin
          rdata_d = iMM_RD_DATA;
          state_d = StRdResp;
        end else begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        tmr_en = 1'b1;
        // Real data beats a coincident expiry.
        if (iMM_RD_DATA_V) begin
          rdata_d = iMM_RD_DATA;
          state_d = StRdResp;
        end else if (tmr_expired) begin
          rdata_d = err_data;
          err_to  = 1'b1;
          state_d = StRdResp;
        end
      end
      StRdResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Strobes are registered, so decode them from the state being entered.
    wr_en_d = (state_d == StWr);
    rd_en_d = (state_d == StRdIssue);
    rd_v_d  = (state_d == StRdResp);
  end

  // Error counters: clear first, then any new error in the same cycle lands.
  always_comb begin
    to_cnt_d = iCLR_ERR ? 16'h0000 : to_cnt_q;
    sticky_d = iCLR_ERR ? 2'b00 : sticky_q;
    if (err_to) begin
      if (to_cnt_d != 16'hFFFF) begin
        to_cnt_d = to_cnt_d + 16'h0001;
      end
      sticky_d[ErrBitTo] = 1'b1;
    end
    if (err_rw) begin
      sticky_d[ErrBitRw] = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_v_q   <= 1'b0;
      to_cnt_q <= '0;
      sticky_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      rd_v_q   <= rd_v_d;
      to_cnt_q <= to_cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign oAV_WAITREQ  = (state_q != StIdle);
  assign oAV_RDDATA   = rdata_q;
  assign oAV_RDDATA_V = rd_v_q;
  assign oMM_ADDR     = addr_q;
  assign oMM_WR_DATA  = wdata_q;
  assign oMM_WR_EN    = wr_en_q;
  assign oMM_RD_EN    = rd_en_q;
  assign oTO_CNT      = to_cnt_q;
  assign oERR_STICKY  = sticky_q;

endmodule
